seq_pattern_tx: RTL and testbench

Serial pattern transmitter that drives a single-bit stream toward the serial sequence detectors. A command loads a pattern of up to MAX_LEN bits, a repeat count and an inter-repetition gap. The block then shifts the pattern out MSB-first, one bit per cycle, and signals completion with a one-cycle done pulse. It is the stimulus/transmit end of the same bit-serial interface the detectors receive.

---
 rtl/seq_pattern_tx_if.sv | 30 +++
 rtl/seq_pattern_tx.sv | 106 ++++++++++
 tb/tb_seq_pattern_tx.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Command and serial-stream bundle for seq_pattern_tx.
// The master side issues commands and observes the stream; the slave side is the transmitter.
interface seq_pattern_tx_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 3
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic [MAX_LEN-1:0] cmd_pattern;
  logic [LEN_W-1:0]   cmd_len;
  logic [CNT_W-1:0]   cmd_repeat;
  logic [GAP_W-1:0]   cmd_gap;
  logic               abort;
  logic               tx_data;
  logic               tx_valid;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_pattern, cmd_len, cmd_repeat, cmd_gap, abort,
    input  cmd_ready, tx_data, tx_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_pattern, cmd_len, cmd_repeat, cmd_gap, abort,
    output cmd_ready, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: first bit one cycle after accept, MSB-first, repeats with gaps, done pulse.
// Accepts a command only in IDLE (cmd_ready); the bit stream itself has no backpressure.
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);
  localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pattern, pattern_n;
  logic [LEN_W-1:0]   len, len_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [CNT_W-1:0]   rep, rep_n;
  logic [GAP_W-1:0]   gap, gap_n;
  logic [GAP_W-1:0]   gcnt, gcnt_n;
  logic [LEN_W-1:0]   eff_len;

  // Oversized lengths clamp to the pattern register width.
  assign eff_len = (bus.cmd_len > MAX_LEN_L) ? MAX_LEN_L : bus.cmd_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pattern <= '0;
      len     <= '0;
      idx     <= '0;
      rep     <= '0;
      gap     <= '0;
      gcnt    <= '0;
    end else begin
      state   <= state_n;
      pattern <= pattern_n;
      len     <= len_n;
      idx     <= idx_n;
      rep     <= rep_n;
      gap     <= gap_n;
      gcnt    <= gcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    pattern_n = pattern;
    len_n     = len;
    idx_n     = idx;
    rep_n     = rep;
    gap_n     = gap;
    gcnt_n    = gcnt;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          pattern_n = bus.cmd_pattern;
          len_n     = eff_len;
          idx_n     = IDX_W'(eff_len - LEN_W'(1));
          rep_n     = bus.cmd_repeat;
          gap_n     = bus.cmd_gap;
          state_n   = (eff_len == '0) ? FIN : SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_n = FIN;
        end else if (idx != '0) begin
          idx_n = idx - IDX_W'(1);
        end else if (rep == '0) begin
          state_n = FIN;
        end else begin
          rep_n = rep - CNT_W'(1);
          // Zero gap restarts the pattern on the very next cycle.
          if (gap == '0) begin
            idx_n = IDX_W'(len - LEN_W'(1));
          end else begin
            state_n = GAP;
            gcnt_n  = gap - GAP_W'(1);
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_n = FIN;
        end else if (gcnt == '0) begin
          state_n = SEND;
          idx_n   = IDX_W'(len - LEN_W'(1));
        end else begin
          gcnt_n = gcnt - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.tx_valid  = (state == SEND);
  assign bus.tx_data   = (state == SEND) & pattern[idx];
  assign bus.busy      = (state == SEND) || (state == GAP);
  assign bus.done      = (state == FIN);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized and directed bench for seq_pattern_tx against a per-cycle expected-output queue.
module tb_seq_pattern_tx;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 4;
  localparam int GAP_W   = 3;
  localparam int K_IDLE  = 0;
  localparam int K_SEND  = 1;
  localparam int K_GAP   = 2;
  localparam int K_FIN   = 3;

  typedef struct {
    int   kind;
    logic d;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int       checks = 0;
  int       errors = 0;
  ent_t     q[$];
  ent_t     cur;
  bit       known = 1'b0;
  int       cyc = 0;
  int       done_at = -1;
  int       vbits = 0;
  int       hits = 0;
  logic [3:0] shreg = 4'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expand a command into the exact cycle-by-cycle output sequence it should produce.
  function automatic void build(input logic [7:0] p, input int l, input int r, input int g);
    int   eff;
    ent_t e;
    eff = (l > MAX_LEN) ? MAX_LEN : l;
    if (eff > 0) begin
      for (int rr = 0; rr <= r; rr++) begin
        for (int i = eff - 1; i >= 0; i--) begin
          e.kind = K_SEND;
          e.d    = p[i];
          q.push_back(e);
        end
        if (rr < r) begin
          for (int k = 0; k < g; k++) begin
            e.kind = K_GAP;
            e.d    = 1'b0;
            q.push_back(e);
          end
        end
      end
    end
    e.kind = K_FIN;
    e.d    = 1'b0;
    q.push_back(e);
  endfunction

  task automatic step(input logic v, input logic [7:0] p, input int l, input int r, input int g,
                      input logic ab, input logic rst);
    logic e_rdy, e_vld, e_dat, e_busy, e_done;
    ent_t e;
    @(negedge clk);
    cyc++;
    if (known) begin
      e_rdy  = (cur.kind == K_IDLE);
      e_vld  = (cur.kind == K_SEND);
      e_dat  = (cur.kind == K_SEND) ? cur.d : 1'b0;
      e_busy = (cur.kind == K_SEND) || (cur.kind == K_GAP);
      e_done = (cur.kind == K_FIN);
      check("cmd_ready", 32'(bus.cmd_ready), 32'(e_rdy));
      check("tx_valid",  32'(bus.tx_valid),  32'(e_vld));
      check("tx_data",   32'(bus.tx_data),   32'(e_dat));
      check("busy",      32'(bus.busy),      32'(e_busy));
      check("done",      32'(bus.done),      32'(e_done));
    end
    if (bus.tx_valid === 1'b1) begin
      vbits++;
      shreg = {shreg[2:0], bus.tx_data};
      if (vbits >= 4 && shreg == 4'b1101) hits++;
    end
    if (bus.done === 1'b1 && done_at < 0) done_at = cyc;

    reset           = rst;
    bus.cmd_valid   = v;
    bus.cmd_pattern = p;
    bus.cmd_len     = LEN_W'(l);
    bus.cmd_repeat  = CNT_W'(r);
    bus.cmd_gap     = GAP_W'(g);
    bus.abort       = ab;

    e.kind = K_IDLE;
    e.d    = 1'b0;
    if (rst) begin
      q.delete();
      cur   = e;
      known = 1'b1;
    end else if (known) begin
      if (cur.kind == K_IDLE && v) begin
        build(p, l, r, g);
        cyc = 0; done_at = -1; vbits = 0; hits = 0; shreg = 4'b0;
      end else if (ab && (cur.kind == K_SEND || cur.kind == K_GAP)) begin
        q.delete();
        e.kind = K_FIN;
        q.push_back(e);
        e.kind = K_IDLE;
      end
      if (q.size() > 0) cur = q.pop_front();
      else cur = e;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] p, input int l, input int r, input int g);
    step(1'b1, p, l, r, g, 1'b0, 1'b0);
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((q.size() > 0 || cur.kind != K_IDLE) && k < max) begin
      idle(1);
      k++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_pattern = '0;
    bus.cmd_len     = '0;
    bus.cmd_repeat  = '0;
    bus.cmd_gap     = '0;
    bus.abort       = 1'b0;

    step(1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 0, 0, 0, 1'b0, 1'b1);
    idle(2);

    // Single shot 1101
    send(8'b0000_1101, 4, 0, 0);
    drain(50);
    check("single_done_at", 32'(done_at), 32'd5);
    check("single_bits", 32'(vbits), 32'd4);
    check("single_pattern", 32'(shreg), 32'b1101);
    idle(1);

    // Back-to-back repetitions into a 1101 detector
    send(8'b0000_1101, 4, 2, 0);
    drain(50);
    check("loop_done_at", 32'(done_at), 32'd13);
    check("loop_bits", 32'(vbits), 32'd12);
    check("loop_hits", 32'(hits), 32'd3);

    // Gapped repetitions
    send(8'b0000_0010, 2, 1, 3);
    drain(50);
    check("gap_done_at", 32'(done_at), 32'd8);
    check("gap_bits", 32'(vbits), 32'd4);

    // Zero length
    send(8'hFF, 0, 3, 2);
    drain(10);
    check("len0_done_at", 32'(done_at), 32'd1);
    check("len0_bits", 32'(vbits), 32'd0);

    // Oversized length clamps to 8 bits
    send(8'hA5, 12, 0, 0);
    drain(50);
    check("len12_bits", 32'(vbits), 32'd8);
    check("len12_done_at", 32'(done_at), 32'd9);
    check("len12_tail", 32'(shreg), 32'b0101);

    // Full-scale repeat and gap
    send(8'h3C, 8, 15, 7);
    drain(400);
    check("full_done_at", 32'(done_at), 32'd234);
    check("full_bits", 32'(vbits), 32'd128);

    // Abort on the third bit, then abort in IDLE alongside a new command
    send(8'hB6, 8, 3, 0);
    idle(2);
    step(1'b0, 8'h00, 0, 0, 0, 1'b1, 1'b0);
    idle(1);
    check("abort_bits", 32'(vbits), 32'd3);
    check("abort_done_at", 32'(done_at), 32'd4);
    step(1'b1, 8'b0000_1101, 4, 0, 0, 1'b1, 1'b0);
    drain(50);
    check("idle_abort_done_at", 32'(done_at), 32'd5);
    check("idle_abort_bits", 32'(vbits), 32'd4);

    // Reset during GAP with cmd_valid held high
    send(8'b0000_0010, 2, 1, 3);
    idle(2);
    step(1'b1, 8'b0000_0010, 2, 1, 3, 1'b0, 1'b1);
    step(1'b1, 8'b0000_0010, 2, 1, 3, 1'b0, 1'b1);
    step(1'b1, 8'b0000_0010, 2, 1, 3, 1'b0, 1'b0);
    drain(50);
    check("reaccept_done_at", 32'(done_at), 32'd8);
    check("reaccept_bits", 32'(vbits), 32'd4);

    // Randomized traffic with sporadic aborts and resets
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 299) == 0));
    end
    drain(500);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
